// File: rtl/secret_coeff_unpacker.sv
// -----------------------------------------------------------------------------
// secret_coeff_unpacker
//
// Streams one polynomial of the sampled secret vector out of BRAM. The
// polynomial is stored as 16 packed 64-bit words. Each word holds 16
// coefficients as 4-bit sign-magnitude nibbles. Nibble j of word w is
// coefficient 16*w+j. The block emits one sign-extended two's-complement
// coefficient per valid/ready handshake. A two-entry word buffer with
// look-ahead reads keeps the stream free of bubbles while the consumer is ready.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin unpacking poly_sel (sampled only while idle)
//   poly_sel     polynomial index, 0..NUM_POLY-1
//   rd_en        BRAM read strobe (registered)
//   rd_address   BRAM word address (registered)
//   data_in      BRAM read data, valid the cycle after rd_en
//   coeff_out    current coefficient, two's complement, OUT_W bits
//   coeff_index  position 0..255 of coeff_out within the polynomial
//   coeff_last   marks coefficient 255 (qualified by coeff_valid)
//   coeff_valid  coeff_out/coeff_index/coeff_last are valid
//   coeff_ready  consumer accepts the current coefficient
//   busy         high from start acceptance until the stream completes
//   done         one-cycle pulse after the final handshake
//   format_err   sticky: an emitted nibble had magnitude 5..7
// -----------------------------------------------------------------------------
module secret_coeff_unpacker #(
   parameter int ADDR_W         = 9,
   parameter int NUM_POLY       = 3,
   parameter int WORDS_PER_POLY = 16,
   parameter int BASE_ADDR      = 0,
   parameter int OUT_W          = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        poly_sel,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_address,
   input  logic [63:0]       data_in,
   output logic [OUT_W-1:0]  coeff_out,
   output logic [7:0]        coeff_index,
   output logic              coeff_last,
   output logic              coeff_valid,
   input  logic              coeff_ready,
   output logic              busy,
   output logic              done,
   output logic              format_err
);

   // Wide enough to count 0..WORDS_PER_POLY inclusive.
   localparam int ISS_W = $clog2(WORDS_PER_POLY + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t state;

   // Word buffer: two slots used as a ring.
   logic [63:0] word_buf [2];
   logic        rd_ptr;        // slot holding the word currently being unpacked
   logic        wr_ptr;        // slot the next returning word lands in
   logic [1:0]  count;         // words held in the buffer
   logic        pend;          // a read issued last cycle returns data this cycle
   logic [ISS_W-1:0] issued;   // reads issued for the current polynomial
   logic        cur_bad;       // the coefficient on coeff_out came from a |mag|>4 nibble

   // Next-state helpers
   logic              hs;
   logic              pop;
   logic              advance;
   logic [7:0]        tgt_idx;
   logic [1:0]        remaining;
   logic [1:0]        count_next;
   logic              head_ptr;
   logic              avail;
   logic [63:0]       src_word;
   logic [3:0]        nib;
   logic              issue;
   logic              sel_ok;
   logic [ADDR_W-1:0] start_addr;

   // Sign-magnitude nibble to sign-extended two's complement. -0 maps to 0.
   function automatic logic [OUT_W-1:0] to_twos(input logic [3:0] n);
      logic [OUT_W-1:0] mag;
      mag = OUT_W'(n[2:0]);
      return n[3] ? -mag : mag;
   endfunction

   always_comb begin
      // NOTE: every signal driven here gets a default first, so a missed
      // branch can never infer a latch.
      hs         = coeff_valid & coeff_ready;
      pop        = 1'b0;
      advance    = 1'b0;
      tgt_idx    = coeff_index;
      remaining  = count;
      head_ptr   = rd_ptr;
      avail      = 1'b0;
      src_word   = data_in;
      nib        = 4'h0;
      count_next = count;
      issue      = 1'b0;
      sel_ok     = (int'(poly_sel) < NUM_POLY);
      start_addr = ADDR_W'(BASE_ADDR + int'(poly_sel) * WORDS_PER_POLY);

      // Accepting nibble 15 retires the head word and frees its slot.
      pop = hs & (coeff_index[3:0] == 4'hF);

      // Load a new coefficient when the output is empty, or when the
      // current one is accepted and it is not the last of the polynomial.
      advance = (state == ST_RUN) & (~coeff_valid | (hs & ~coeff_last));
      tgt_idx = hs ? (coeff_index + 8'd1) : coeff_index;

      // The word that will be at the head after this edge: a word already
      // held in the buffer, or the word returning from BRAM right now
      // (bypass, so the first coefficient appears in the capture cycle).
      remaining = count - {1'b0, pop};
      head_ptr  = rd_ptr ^ pop;
      if (remaining != 2'd0) begin
         src_word = word_buf[head_ptr];
         avail    = 1'b1;
      end else if (pend) begin
         src_word = data_in;
         avail    = 1'b1;
      end
      nib = src_word[{tgt_idx[3:0], 2'b00} +: 4];

      count_next = count + {1'b0, pend} - {1'b0, pop};

      // Look-ahead read: words held plus reads in flight never exceed the
      // two buffer slots. rd_en of this cycle becomes in-flight next cycle.
      issue = (state == ST_RUN) && (issued < ISS_W'(WORDS_PER_POLY))
              && ((3'(count_next) + 3'(rd_en)) < 3'd2);
   end

   // NOTE: the buffer array is deliberately left out of reset; clearing
   // count/pointers empties it logically, and an unreset array maps onto
   // plain storage instead of a bank of resettable flops.
   always_ff @(posedge clk) begin
      if (pend) begin
         word_buf[wr_ptr] <= data_in;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // sees the pre-edge values of every other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         rd_en       <= 1'b0;
         rd_address  <= '0;
         pend        <= 1'b0;
         count       <= 2'd0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         issued      <= '0;
         coeff_out   <= '0;
         coeff_index <= 8'd0;
         coeff_last  <= 1'b0;
         coeff_valid <= 1'b0;
         cur_bad     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         format_err  <= 1'b0;
      end else begin
         done  <= 1'b0;
         rd_en <= 1'b0;
         pend  <= rd_en;
         count <= count_next;
         if (pend) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (hs && cur_bad) begin
            format_err <= 1'b1;
         end

         unique case (state)
            ST_IDLE: begin
               if (start && sel_ok) begin
                  state       <= ST_RUN;
                  busy        <= 1'b1;
                  format_err  <= 1'b0;
                  rd_en       <= 1'b1;
                  rd_address  <= start_addr;
                  issued      <= ISS_W'(1);
                  coeff_index <= 8'd0;
                  coeff_valid <= 1'b0;
                  coeff_last  <= 1'b0;
               end
            end

            ST_RUN: begin
               if (hs && coeff_last) begin
                  state       <= ST_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  coeff_valid <= 1'b0;
                  coeff_last  <= 1'b0;
               end else if (advance) begin
                  coeff_valid <= avail;
                  coeff_index <= tgt_idx;
                  coeff_out   <= to_twos(nib);
                  coeff_last  <= avail & (tgt_idx == 8'd255);
                  cur_bad     <= nib[2:0] > 3'd4;
               end
               if (issue) begin
                  rd_en      <= 1'b1;
                  rd_address <= rd_address + ADDR_W'(1);
                  issued     <= issued + ISS_W'(1);
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secret_coeff_unpacker.sv
// -----------------------------------------------------------------------------
// Testbench for secret_coeff_unpacker. A BRAM model answers reads one cycle
// later. Expected coefficients are derived directly from the stored words.
// Each coefficient is taken nibble by nibble, sign/magnitude to integer.
// -----------------------------------------------------------------------------
module tb_secret_coeff_unpacker;

   localparam int ADDR_W = 9;
   localparam int OUT_W  = 13;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        poly_sel;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_address;
   logic [63:0]       data_in;
   logic [OUT_W-1:0]  coeff_out;
   logic [7:0]        coeff_index;
   logic              coeff_last;
   logic              coeff_valid;
   logic              coeff_ready;
   logic              busy;
   logic              done;
   logic              format_err;

   int total = 0;
   int bad   = 0;

   logic [63:0] mem [512];

   always #5 clk = ~clk;

   secret_coeff_unpacker dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .poly_sel    (poly_sel),
      .rd_en       (rd_en),
      .rd_address  (rd_address),
      .data_in     (data_in),
      .coeff_out   (coeff_out),
      .coeff_index (coeff_index),
      .coeff_last  (coeff_last),
      .coeff_valid (coeff_valid),
      .coeff_ready (coeff_ready),
      .busy        (busy),
      .done        (done),
      .format_err  (format_err)
   );

   // BRAM model: a read seen mid-cycle returns data for the whole next cycle.
   // Cycles with no read return junk, so a mistimed capture shows up.
   logic              rd_seen;
   logic [ADDR_W-1:0] rd_seen_addr;
   initial begin
      rd_seen = 1'b0;
      rd_seen_addr = '0;
      data_in = 64'd0;
   end
   always @(negedge clk) begin
      rd_seen      = rd_en;
      rd_seen_addr = rd_address;
   end
   always @(posedge clk) begin
      #1;
      data_in = rd_seen ? mem[rd_seen_addr] : {$urandom, $urandom};
   end

   // Reference: coefficient i of polynomial p.
   function automatic logic [OUT_W-1:0] model_coeff(input int p, input int i);
      logic [63:0] w;
      int nibv, mag, val;
      w    = mem[p * 16 + i / 16];
      nibv = int'((w >> (4 * (i % 16))) & 64'hF);
      mag  = nibv % 8;
      val  = (nibv >= 8) ? -mag : mag;
      return OUT_W'(val);
   endfunction

   function automatic bit model_bad(input int p, input int i);
      logic [63:0] w;
      int nibv;
      w    = mem[p * 16 + i / 16];
      nibv = int'((w >> (4 * (i % 16))) & 64'hF);
      return (nibv % 8) > 4;
   endfunction

   // Starts poly p at the current negedge and follows the stream to the end.
   // Checks addresses, outstanding reads, ordering, values, stall stability,
   // format_err and busy/done. Returns at a negedge.
   task automatic run_stream(input int p, input int ready_pct, input int abort_at,
                             input bit poke, output int first_valid_n,
                             output int done_n, output bit aborted);
      int k, n, issued, consumed;
      bit prev_valid, prev_hs, finished, saw_bad, hs;
      logic [OUT_W-1:0] prev_out;
      logic [7:0]       prev_idx;
      logic             prev_last;
      k = 0; n = 0; issued = 0; consumed = 0;
      prev_valid = 0; prev_hs = 0; finished = 0; saw_bad = 0; hs = 0;
      prev_out = '0; prev_idx = '0; prev_last = 0;
      first_valid_n = -1; done_n = -1; aborted = 0;
      start = 1'b1;
      poly_sel = 2'(p);
      coeff_ready = ($urandom_range(99) < ready_pct);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      while (!finished && n < 3000) begin
         hs = 0;
         if (rd_en === 1'b1) begin
            total++;
            if (rd_address !== ADDR_W'(p * 16 + issued)) begin
               bad++;
               $display("FAIL rd_address p%0d: got %0d want %0d", p, rd_address, p * 16 + issued);
            end
            issued++;
         end
         total++;
         if (issued - consumed > 2 || issued > 16) begin
            bad++;
            $display("FAIL outstanding p%0d: issued=%0d consumed=%0d", p, issued, consumed);
         end
         if (prev_valid && !prev_hs) begin
            total++;
            if (coeff_valid !== 1'b1 || coeff_out !== prev_out ||
                coeff_index !== prev_idx || coeff_last !== prev_last) begin
               bad++;
               $display("FAIL stall_stable p%0d: got v=%b %h/%0d/%b want 1 %h/%0d/%b",
                        p, coeff_valid, coeff_out, coeff_index, coeff_last,
                        prev_out, prev_idx, prev_last);
            end
         end
         total++;
         if (format_err !== saw_bad) begin
            bad++;
            $display("FAIL format_err p%0d k=%0d: got %b want %b", p, k, format_err, saw_bad);
         end
         if (k == 256) begin
            done_n = n;
            total++;
            if (done !== 1'b1 || busy !== 1'b0 || coeff_valid !== 1'b0) begin
               bad++;
               $display("FAIL done_pulse p%0d: got done=%b busy=%b valid=%b want 1 0 0",
                        p, done, busy, coeff_valid);
            end
            finished = 1;
            start = 1'b0;
         end else begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               bad++;
               $display("FAIL busy_run p%0d n=%0d: got busy=%b done=%b want 1 0", p, n, busy, done);
            end
            if (coeff_valid === 1'b1) begin
               if (first_valid_n < 0) first_valid_n = n;
               total++;
               if (coeff_out !== model_coeff(p, k) || coeff_index !== 8'(k) ||
                   coeff_last !== (k == 255)) begin
                  bad++;
                  $display("FAIL coeff p%0d: got %h idx=%0d last=%b want %h idx=%0d last=%b",
                           p, coeff_out, coeff_index, coeff_last, model_coeff(p, k), k, k == 255);
               end
               if (abort_at >= 0 && k == abort_at) begin
                  aborted = 1;
                  start = 1'b0;
                  return;
               end
            end
            coeff_ready = ($urandom_range(99) < ready_pct);
            start = poke && k < 240 && ($urandom_range(3) == 0);
            poly_sel = 2'($urandom_range(3));
            hs = (coeff_valid === 1'b1) && coeff_ready;
            if (hs) begin
               if (model_bad(p, k)) saw_bad = 1;
               if (k % 16 == 15) consumed++;
               k++;
            end
         end
         prev_valid = (coeff_valid === 1'b1);
         prev_hs    = hs;
         prev_out   = coeff_out;
         prev_idx   = coeff_index;
         prev_last  = coeff_last;
         if (!finished) begin
            @(negedge clk);
            n++;
         end
      end
      if (!finished) begin
         total++;
         bad++;
         $display("FAIL timeout p%0d: got %0d handshakes want 256", p, k);
      end else begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || coeff_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_done p%0d: got done=%b busy=%b valid=%b want 0 0 0",
                     p, done, busy, coeff_valid);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      poly_sel = 2'd0;
      coeff_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({rd_en, rd_address, coeff_valid, coeff_out, coeff_index, coeff_last,
           busy, done, format_err} !== 36'd0) begin
         bad++;
         $display("FAIL reset_state: got en=%b addr=%0d v=%b out=%h idx=%0d busy=%b done=%b err=%b",
                  rd_en, rd_address, coeff_valid, coeff_out, coeff_index, busy, done, format_err);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int fv, dn;
      bit ab;
      for (int i = 0; i < 512; i++) mem[i] = 64'd0;
      mem[0] = 64'h0000_0000_0000_9C41;
      run_stream(0, 100, -1, 0, fv, dn, ab);
      total++;
      if (fv !== 2) begin
         bad++;
         $display("FAIL first_valid_latency: got %0d want 2", fv);
      end
      total++;
      if (dn !== 258) begin
         bad++;
         $display("FAIL done_latency: got %0d want 258", dn);
      end
   endtask

   task automatic test_random_ready();
      int fv, dn;
      bit ab;
      for (int i = 16; i < 32; i++) mem[i] = {$urandom, $urandom};
      run_stream(1, 50, -1, 0, fv, dn, ab);
   endtask

   task automatic test_format();
      int fv, dn;
      bit ab;
      for (int i = 0; i < 16; i++) mem[i] = 64'd0;
      mem[0] = 64'h0000_0000_0000_0D58;
      run_stream(0, 100, -1, 0, fv, dn, ab);
      total++;
      if (format_err !== 1'b1) begin
         bad++;
         $display("FAIL format_sticky: got %b want 1", format_err);
      end
      mem[0] = 64'd0;
      run_stream(0, 80, -1, 0, fv, dn, ab);
      total++;
      if (format_err !== 1'b0) begin
         bad++;
         $display("FAIL format_cleared: got %b want 0", format_err);
      end
   endtask

   task automatic test_mid_reset();
      int fv, dn;
      bit ab;
      for (int i = 32; i < 48; i++) mem[i] = {$urandom, $urandom};
      run_stream(2, 70, 100, 0, fv, dn, ab);
      total++;
      if (ab !== 1'b1) begin
         bad++;
         $display("FAIL abort_reached: got %b want 1", ab);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({rd_en, rd_address, coeff_valid, coeff_out, coeff_index, coeff_last,
           busy, done, format_err} !== 36'd0) begin
         bad++;
         $display("FAIL midstream_reset: got en=%b addr=%0d v=%b out=%h idx=%0d busy=%b err=%b",
                  rd_en, rd_address, coeff_valid, coeff_out, coeff_index, busy, format_err);
      end
      @(negedge clk);
      rst = 1'b1;
      coeff_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (rd_en !== 1'b0 || coeff_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_quiet c%0d: got en=%b v=%b busy=%b want 0 0 0",
                     c, rd_en, coeff_valid, busy);
         end
      end
      run_stream(2, 100, -1, 0, fv, dn, ab);
   endtask

   task automatic test_ignored_start();
      int fv, dn;
      bit ab;
      start = 1'b1;
      poly_sel = 2'd3;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (rd_en !== 1'b0 || busy !== 1'b0 || coeff_valid !== 1'b0) begin
            bad++;
            $display("FAIL bad_poly_ignored c%0d: got en=%b busy=%b v=%b want 0 0 0",
                     c, rd_en, busy, coeff_valid);
         end
      end
      start = 1'b0;
      // Random starts while busy must leave the stream untouched.
      run_stream(1, 60, -1, 1, fv, dn, ab);
      // Back-to-back: start lands in the idle cycle right after done.
      run_stream(0, 100, -1, 0, fv, dn, ab);
      total++;
      if (fv !== 2) begin
         bad++;
         $display("FAIL back_to_back_latency: got %0d want 2", fv);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random_ready();
      test_format();
      test_mid_reset();
      test_ignored_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
